// File: rtl/core_dbg_apb_master_if.sv
// Bus bundle for core_dbg_apb_master.
// Carries the requester handshake (req_*/rsp_*) and the APB master signals.
//   master modport : the APB master block (consumes requests, drives APB).
//   slave  modport : the environment side (requester plus APB slave).
interface core_dbg_apb_master_if #(
  parameter int unsigned APB_ADDR_WIDTH = 5,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  // requester side
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_wr_rd;
  logic [APB_ADDR_WIDTH-1:0] req_addr;
  logic [APB_DATA_WIDTH-1:0] req_wdata;
  logic [3:0]                req_wstrobe;
  logic                      rsp_valid;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata;
  logic                      rsp_timeout;
  // APB side
  logic [APB_ADDR_WIDTH-1:0] addr;
  logic                      sel;
  logic                      enable;
  logic                      wr_rd;
  logic [APB_DATA_WIDTH-1:0] wdata;
  logic [3:0]                wstrobe;
  logic                      ready;
  logic [APB_DATA_WIDTH-1:0] rdata;

  modport master (
    input  req_valid, req_wr_rd, req_addr, req_wdata, req_wstrobe, ready, rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           addr, sel, enable, wr_rd, wdata, wstrobe
  );

  modport slave (
    output req_valid, req_wr_rd, req_addr, req_wdata, req_wstrobe, ready, rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
           addr, sel, enable, wr_rd, wdata, wstrobe
  );
endinterface

// File: rtl/core_dbg_apb_master.sv
// APB master for core debug register transfers.
// Turns single read/write requests from the JTAG debug front end into
// two-phase APB transfers (SETUP, ACCESS with wait states) and returns a
// one-cycle response carrying read data or a timeout flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : core_dbg_apb_master_if.master (req_*, rsp_*, APB signals)
module core_dbg_apb_master #(
  parameter int unsigned APB_ADDR_WIDTH = 5,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  core_dbg_apb_master_if.master  bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      wr_rd_q, wr_rd_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic                      sel, enable, req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wr_rd_q       <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wr_rd_q       <= wr_rd_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wr_rd_d       = wr_rd_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    // Response registers default to zero so the response is a single pulse
    // and rsp_rdata reads 0 outside it.
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_timeout_d = 1'b0;
    sel           = 1'b0;
    enable        = 1'b0;
    req_ready     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wr_rd_d = bus.req_wr_rd;
          wdata_d = bus.req_wr_rd ? bus.req_wdata : '0;
          wstrb_d = bus.req_wr_rd ? bus.req_wstrobe : '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        sel     = 1'b1;
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        sel    = 1'b1;
        enable = 1'b1;
        // ready is checked first so a completion on the last allowed cycle
        // is not reported as a timeout.
        if (bus.ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_rd_q ? '0 : bus.rdata;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          // saturates so an unbounded wait (TIMEOUT == 0) never wraps
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready   = req_ready;
  assign bus.sel         = sel;
  assign bus.enable      = enable;
  assign bus.addr        = addr_q;
  assign bus.wr_rd       = wr_rd_q;
  assign bus.wdata       = wdata_q;
  assign bus.wstrobe     = wstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule
